// File: rtl/mem_bus_ctrl_pkg.sv
// Shared constants for the CPU data-port memory controller: default region map,
// FSM state encoding and wait-counter width.
package mem_bus_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [31:0] ROM_BEGIN = 32'h0001_0000;
    localparam logic [31:0] ROM_END   = 32'h000F_FFFF;
    localparam logic [31:0] RAM_BEGIN = 32'h0010_0000;
    localparam logic [31:0] RAM_END   = 32'hFF0F_FFFF;
    localparam logic [31:0] IO_BEGIN  = 32'hFF10_0000;
    localparam logic [31:0] IO_END    = 32'hFF10_00FF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_ERR
    } state_t;

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational region decoder: inclusive base/end compare per region,
// lowest index wins, returns region-relative address and write permission.
module mem_bus_decoder #(
    parameter int                    NREG  = 3,
    parameter int                    AW    = 32,
    parameter int                    IW    = 2,
    parameter logic [NREG*AW-1:0]    BASES = '0,
    parameter logic [NREG*AW-1:0]    ENDS  = '0,
    parameter logic [NREG-1:0]       WR    = '0
) (
    input  logic [AW-1:0]   addr,
    output logic            hit,
    output logic [NREG-1:0] sel,
    output logic [IW-1:0]   idx,
    output logic [AW-1:0]   rel_addr,
    output logic            writable
);

    logic [NREG-1:0] hits;

    for (genvar i = 0; i < NREG; i++) begin : g_cmp
        assign hits[i] = (addr >= BASES[i*AW +: AW]) && (addr <= ENDS[i*AW +: AW]);
    end

    assign hit = |hits;

    // Walk from the highest index down so the lowest-index hit overrides.
    always_comb begin
        sel      = '0;
        idx      = '0;
        rel_addr = '0;
        writable = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                idx      = IW'(i);
                rel_addr = addr - BASES[i*AW +: AW];
                writable = WR[i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU data-port controller: decodes into NREG regions, drives one-hot device
// selects with per-region wait states, returns data/error via req/ready.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int                     NREG        = 3,
    parameter int                     AW          = 32,
    parameter int                     DW          = 32,
    parameter logic [NREG*AW-1:0]     REGION_BASE = {IO_BEGIN, RAM_BEGIN, ROM_BEGIN},
    parameter logic [NREG*AW-1:0]     REGION_END  = {IO_END, RAM_END, ROM_END},
    parameter logic [NREG*CNT_W-1:0]  REGION_WAIT = {4'd2, 4'd1, 4'd0},
    parameter logic [NREG-1:0]        REGION_WR   = 3'b110
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DW-1:0]       wd,
    input  logic [DW/8-1:0]     be,
    output logic                ready,
    output logic                err,
    output logic [DW-1:0]       rd,
    output logic [NREG-1:0]     dev_sel,
    output logic                dev_we,
    output logic [DW/8-1:0]     dev_be,
    output logic [AW-1:0]       dev_addr,
    output logic [DW-1:0]       dev_wd,
    input  logic [NREG*DW-1:0]  dev_rd
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int AL = $clog2(DW / 8);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IW-1:0]      idx_q;
    logic               we_q;

    logic               dec_hit;
    logic [NREG-1:0]    dec_sel;
    logic [IW-1:0]      dec_idx;
    logic [AW-1:0]      dec_rel;
    logic               dec_wr;
    logic               bad;

    logic [NREG-1:0][DW-1:0] dev_rd_a;

    mem_bus_decoder #(
        .NREG  (NREG),
        .AW    (AW),
        .IW    (IW),
        .BASES (REGION_BASE),
        .ENDS  (REGION_END),
        .WR    (REGION_WR)
    ) u_dec (
        .addr     (addr),
        .hit      (dec_hit),
        .sel      (dec_sel),
        .idx      (dec_idx),
        .rel_addr (dec_rel),
        .writable (dec_wr)
    );

    assign bad = !dec_hit || (addr[AL-1:0] != '0) || (we && !dec_wr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            dev_sel  <= '0;
            dev_we   <= 1'b0;
            dev_be   <= '0;
            dev_addr <= '0;
            dev_wd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (bad) begin
                            state <= S_ERR;
                        end else begin
                            state    <= S_ACCESS;
                            dev_sel  <= dec_sel;
                            dev_addr <= dec_rel;
                            dev_wd   <= wd;
                            dev_be   <= be;
                            dev_we   <= we;
                            we_q     <= we;
                            idx_q    <= dec_idx;
                            cnt      <= REGION_WAIT[dec_idx*CNT_W +: CNT_W];
                        end
                    end
                end
                S_ACCESS: begin
                    // Write strobe lives only in the first ACCESS cycle.
                    dev_we <= 1'b0;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= S_RESP;
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    dev_sel  <= '0;
                    dev_addr <= '0;
                    dev_wd   <= '0;
                    dev_be   <= '0;
                end
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dev_rd_a = dev_rd;
    assign ready    = (state == S_RESP) || (state == S_ERR);
    assign err      = (state == S_ERR);
    assign rd       = (state == S_RESP && !we_q) ? dev_rd_a[idx_q] : '0;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed map/boundary cases plus random
// accesses, expectations from a region-table reference model.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ready;
    logic        err;
    logic [31:0] rd;
    logic [2:0]  dev_sel;
    logic        dev_we;
    logic [3:0]  dev_be;
    logic [31:0] dev_addr;
    logic [31:0] dev_wd;
    logic [95:0] dev_rd;

    mem_bus_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wd       (wd),
        .be       (be),
        .ready    (ready),
        .err      (err),
        .rd       (rd),
        .dev_sel  (dev_sel),
        .dev_we   (dev_we),
        .dev_be   (dev_be),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_rd   (dev_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference region table, written out from the memory map.
    logic [31:0] m_base [3] = '{32'h0001_0000, 32'h0010_0000, 32'hFF10_0000};
    logic [31:0] m_end  [3] = '{32'h000F_FFFF, 32'hFF0F_FFFF, 32'hFF10_00FF};
    int          m_wait [3] = '{0, 1, 2};
    bit          m_wr   [3] = '{0, 1, 1};

    typedef struct {
        bit          err;
        logic [31:0] rd;
        logic [2:0]  sel;
        logic [31:0] rel;
        bit          we;
        logic [31:0] wd;
        logic [3:0]  be;
        int          rcyc;
        int          nsel;
        int          nwe;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 1'b0;
    int   sel_cyc = 0;
    int   we_cnt = 0;
    exp_t e;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dev_we) we_cnt++;
            if (dev_sel != 3'b000) begin
                sel_cyc++;
                if (q.size() == 0) chk("spurious_sel", 64'(dev_sel), 64'd0);
                else begin
                    chk("dev_sel", 64'(dev_sel), 64'(q[0].sel));
                    chk("dev_addr", 64'(dev_addr), 64'(q[0].rel));
                    if (q[0].we) begin
                        chk("dev_wd", 64'(dev_wd), 64'(q[0].wd));
                        chk("dev_be", 64'(dev_be), 64'(q[0].be));
                    end
                end
            end
            if (ready) begin
                if (q.size() == 0) chk("spurious_ready", 64'(ready), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("err", 64'(err), 64'(e.err));
                    chk("rd", 64'(rd), 64'(e.rd));
                    chk("ready_cycle", 64'(cyc), 64'(e.rcyc));
                    chk("sel_cycles", 64'(sel_cyc), 64'(e.nsel));
                    chk("dev_we_pulses", 64'(we_cnt), 64'(e.nwe));
                end
                sel_cyc = 0;
                we_cnt  = 0;
            end
        end
    end

    // Issue one access at a negedge; the following posedge samples it.
    task automatic do_txn(input logic [31:0] a, input bit w, input logic [31:0] d,
                          input logic [3:0] b);
        exp_t x;
        int   r = -1;
        int   t = 0;
        for (int i = 0; i < 3; i++)
            if (r < 0 && a >= m_base[i] && a <= m_end[i]) r = i;
        for (int i = 0; i < 3; i++) dev_rd[i*32 +: 32] = $urandom;
        x.err = (r < 0) || (a[1:0] != 2'b00) || (w && !m_wr[r]);
        x.we  = w;
        x.wd  = d;
        x.be  = b;
        if (x.err) begin
            x.rd = '0; x.sel = '0; x.rel = '0;
            x.rcyc = cyc + 1; x.nsel = 0; x.nwe = 0;
        end else begin
            x.rd   = w ? 32'd0 : dev_rd[r*32 +: 32];
            x.sel  = 3'(1 << r);
            x.rel  = a - m_base[r];
            x.rcyc = cyc + 2 + m_wait[r];
            x.nsel = 2 + m_wait[r];
            x.nwe  = w ? 1 : 0;
        end
        q.push_back(x);
        req = 1'b1; we = w; addr = a; wd = d; be = b;
        @(negedge clk);
        req = 1'b0; we = 1'b0; addr = $urandom; wd = $urandom; be = 4'($urandom);
        while (q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr(input int r, input int kind);
        logic [31:0] span;
        span = m_end[r] - m_base[r] + 1;
        case (kind)
            0: return m_base[r];
            1: return m_end[r] & ~32'd3;
            2: return (m_base[r] + ($urandom % span)) & ~32'd3;
            3: return m_end[r] + 1;
            4: return m_base[r] - 4;
            5: return m_base[r] + 32'(($urandom_range(1, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wd = '0; be = '0; dev_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_dev_sel", 64'(dev_sel), 64'd0);
        chk("rst_dev_we", 64'(dev_we), 64'd0);
        chk("rst_dev_addr", 64'(dev_addr), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        do_txn(32'h0001_0010, 1'b0, 32'h0, 4'hF);
        do_txn(32'h0010_0040, 1'b1, 32'h1234_5678, 4'b0011);
        do_txn(32'hFF10_0004, 1'b0, 32'h0, 4'hF);
        do_txn(32'hFF10_0008, 1'b1, 32'hA5A5_5A5A, 4'b1100);
        do_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF);
        do_txn(32'h0001_0000, 1'b1, 32'h1111_1111, 4'hF);
        do_txn(32'h0010_0002, 1'b0, 32'h0, 4'hF);
        do_txn(32'h000F_FFFC, 1'b0, 32'h0, 4'hF);
        do_txn(32'hFF0F_FFFC, 1'b0, 32'h0, 4'hF);
        do_txn(32'hFF10_0100, 1'b0, 32'h0, 4'hF);
        do_txn(32'h0010_0000, 1'b0, 32'h0, 4'hF);
        do_txn(32'hFF10_00FC, 1'b0, 32'h0, 4'hF);
        do_txn(32'h0000_FFFC, 1'b0, 32'h0, 4'hF);

        // Reset in the second ACCESS cycle of an IO write.
        mon_en = 1'b0;
        req = 1'b1; we = 1'b1; addr = 32'hFF10_0010; wd = 32'hCAFE_F00D; be = 4'hF;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("abort_first_we", 64'(dev_we), 64'd1);
        chk("abort_sel", 64'(dev_sel), 64'd4);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("abort_dev_sel", 64'(dev_sel), 64'd0);
        chk("abort_dev_we", 64'(dev_we), 64'd0);
        chk("abort_dev_wd", 64'(dev_wd), 64'd0);
        chk("abort_dev_be", 64'(dev_be), 64'd0);
        chk("abort_dev_addr", 64'(dev_addr), 64'd0);
        chk("abort_ready", 64'(ready), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_ready", 64'(ready), 64'd0);
            chk("post_abort_we", 64'(dev_we), 64'd0);
        end
        mon_en = 1'b1;
        do_txn(32'hFF10_0010, 1'b1, 32'h0BAD_F00D, 4'b0101);
        do_txn(32'h0001_0020, 1'b0, 32'h0, 4'hF);

        for (int n = 0; n < 80; n++) begin
            do_txn(pick_addr($urandom_range(0, 2), $urandom_range(0, 6)),
                   1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Parametrised successor to the fixed ROM/RAM/IO memory interface.
- Decodes CPU data-port accesses into NREG address regions. Each region has its own wait-state count and write permission.
- Drives one-hot device selects with region-relative addresses and returns read data through a req/ready handshake.
- Flags an error response for unmapped, misaligned or read-only-write accesses.
- Sits between the CPU load/store unit and the RAM/ROM/IO blocks.

Parameters:
- NREG, 3, number of regions; region 0 has highest decode priority.
- AW, 32, address width.
- DW, 32, data width; DW/8 byte lanes.
- REGION_BASE, {32'hFF10_0000, 32'h0010_0000, 32'h0001_0000}, packed NREG*AW inclusive base addresses; region 0 is the LSB slice.
- REGION_END, {32'hFF10_00FF, 32'hFF0F_FFFF, 32'h000F_FFFF}, packed NREG*AW inclusive end addresses.
- REGION_WAIT, {4'd2, 4'd1, 4'd0}, packed NREG*4 wait states per region, 0..15.
- REGION_WR, 3'b110, bit i set = region i writable.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- req  in  1  CPU access request; sampled only in IDLE
- we  in  1  write request, qualified by req
- addr  in  AW  byte address
- wd  in  DW  write data
- be  in  DW/8  byte enables for writes
- ready  out  1  one-cycle response strobe
- err  out  1  error response, valid with ready
- rd  out  DW  read data, valid with ready
- dev_sel  out  NREG  one-hot device select
- dev_we  out  1  device write strobe
- dev_be  out  DW/8  device byte enables
- dev_addr  out  AW  region-relative address
- dev_wd  out  DW  device write data
- dev_rd  in  NREG*DW  packed synchronous-read data from the devices, slice i from device i

Behaviour:
- Reset: synchronous active-low. Whenever rstn=0 at a rising edge:
  - state goes to IDLE;
  - ready, err, rd, dev_sel, dev_we, dev_be, dev_addr, dev_wd all become 0;
  - the wait counter becomes 0.
  - Reset during ACCESS or RESP aborts the transaction; no further dev_we is issued.
- Decode:
  - hit[i] = base_i <= addr <= end_i.
  - The lowest-index hit wins.
  - Relative address = addr - base_i, AW-bit unsigned.
- Error conditions: no hit; addr[1:0] != 0; or we=1 to a region with REGION_WR[i]=0.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - At an edge with req=1 and an error condition: go to ERR.
  - At an edge with req=1 and no error: latch region, relative address, wd, be and we; load counter = REGION_WAIT[i]; go to ACCESS.
- ERR: ready=1, err=1, rd=0, dev_sel=0 for exactly one cycle; then IDLE. No device is touched.
- ACCESS:
  - dev_sel, dev_addr, dev_wd and dev_be are held stable.
  - dev_we = latched we in the first ACCESS cycle only, so each write happens exactly once.
  - While counter != 0: decrement and stay in ACCESS. When counter == 0: go to RESP.
  - ACCESS therefore lasts 1+W cycles.
- RESP:
  - dev_sel is still held; ready=1, err=0.
  - rd = dev_rd slice of the selected region on reads, 0 on writes.
  - Next state is IDLE.
- Latency: req sampled at edge k gives ready in cycle k+2+W. Error responses come at cycle k+1.
- req is ignored outside IDLE. The master must drop req in the ready cycle; if req is still high at the first IDLE edge, a new transaction starts. There is a minimum one-cycle IDLE bubble between transactions.
- Outputs: dev_* are registered. ready/err are decoded from state. rd is muxed combinationally in RESP and is 0 otherwise.
- Boundaries:
  - addr == base and addr == end both hit.
  - end+1 misses, unless another region covers it.
  - Overlapping regions resolve to the lower index.
  - W=15 gives 16 ACCESS cycles.

Decomposition:
- Shared package/header (the existing consts include): ROM/RAM/IO begin/end constants, state encodings, and the wait-counter width (4).
- One natural sub-module: mem_bus_decoder. It is combinational and parametrised by NREG/AW and the packed bases/ends. Outputs: hit, one-hot sel, index, relative address, writable flag.
- The FSM, counter and response mux stay in mem_bus_ctrl.

Test Plan:
- Read ROM, default parameters: req, we=0, addr=0x0001_0010, dev_rd[0]=0xDEADBEEF at edge 0 -> dev_sel=001 and dev_addr=0x10 in cycle 1; ready=1, err=0, rd=0xDEADBEEF in cycle 2.
- Write RAM: we=1, addr=0x0010_0040, wd=0x12345678, be=4'b0011 -> dev_sel=010 and dev_addr=0x40; dev_we high exactly one cycle (cycle 1); ready in cycle 3 (W=1); rd=0.
- IO read: addr=0xFF10_0004 -> dev_sel=100 and dev_addr=4 for 3 ACCESS cycles; ready in cycle 4.
- Errors:
  - addr=0x0000_0100 -> err=1 and ready=1 in cycle 1, dev_sel=0, no dev_we.
  - we=1 to 0x0001_0000 -> err=1.
  - addr=0x0010_0002 -> err=1.
- Boundaries: addr=0x000F_FFFC -> ROM. 0xFF0F_FFFC -> RAM. 0xFF10_0100 -> err.
- Reset: rstn=0 in the second ACCESS cycle of an IO write -> next cycle IDLE, all outputs 0, no ready. A new req after reset completes normally.
